fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the team's synchronous `FIFO`. It drains words through the FIFO read port (`rd_n` strobe, `data_out`, `empty`, `underflow`) and re-presents them on a valid/ready output stream toward downstream consumers. It hides the FIFO's one-cycle read latency behind a 3-entry output buffer, so it can sustain one word per cycle. It also marks burst boundaries and records FIFO underflow errors.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `BURST_LEN`, 4: number of accepted words per burst; `m_last` flags the final word of each burst. Legal range 1..256.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  level; high = fetch from the FIFO, low = stop fetching and drain.
- `fifo_rd_n`  out  1  read strobe to the FIFO `rd_n`; high-active, as the FIFO defines it.
- `fifo_data`  in  DATA_WIDTH  from the FIFO `data_out`.
- `fifo_empty`  in  1  from the FIFO `empty`.
- `fifo_underflow`  in  1  from the FIFO `underflow`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  last word of a burst; qualified by `m_valid`.
- `busy`  out  1  state is not IDLE, or the buffer or in-flight read is non-empty.
- `err_underflow`  out  1  sticky underflow error flag.

## Operation
- FIFO contract: if `fifo_rd_n` is high at edge N, the word is valid on `fifo_data` during the cycle after edge N and is captured at edge N+1.
- States:
  - IDLE: no fetching. Go to RUN when `en`=1.
  - RUN: fetching. Go to STOP when `en`=0.
  - STOP: no new reads; wait for the in-flight read to land. Go to IDLE when `inflight`=0, or back to RUN when `en`=1.
- Read issue: `fifo_rd_n` = (state==RUN) && !`fifo_empty` && (`count`+`inflight` ≤ 2).
  - `count` is the buffer occupancy, 0..3.
  - `inflight` is a 1-bit register: it is set by the issue and cleared when the data is captured.
- `fifo_rd_n` depends only on registered state and `fifo_empty`. There is no combinational path from `m_ready`.
- Buffer: 3-entry circular buffer.
  - Push when `inflight`=1.
  - Pop on `m_valid && m_ready`.
  - A simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo 3.
- `m_valid` = `count`≠0; `m_data` = head entry. Both are held stable while `m_valid && !m_ready`.
- Burst counter `beat`, of width clog2(`BURST_LEN`) (minimum 1 bit):
  - Increments on each handshake and wraps to 0 after `BURST_LEN`-1.
  - `m_last` = `m_valid` && (`beat` == `BURST_LEN`-1).
  - When `BURST_LEN`=1, `m_last` = `m_valid`.
- `err_underflow`: set on any cycle with `fifo_underflow`=1. It is cleared only by reset.
- Words already buffered stay presentable in IDLE and STOP.
- Deasserting `en` never drops a word.

## Timing
- Reset values: state IDLE; `fifo_rd_n`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `err_underflow`=0; all counters and pointers 0.
- Reset mid-operation discards buffered and in-flight data.
- Latency: an `en`=1 edge moves the state to RUN. The first read issues in the next cycle if `fifo_empty`=0. The first `m_valid` comes 2 edges after `en` is sampled high.
- Throughput: 1 word/cycle sustained when `m_ready`=1 and the FIFO is non-empty.
- With `m_ready`=0, at most 3 reads are issued, then `fifo_rd_n` stays low.
- `fifo_empty` rising in the cycle after the last read: no further strobes are issued, so the controller never causes FIFO underflow.

## Structure
- Shared package `fifo_pkg`: `DATA_WIDTH` default, state enum (IDLE/RUN/STOP), and buffer depth constant 3.
- One sub-module, `fifo_rd_skid`: the 3-entry buffer with push/pop/count. The FSM, issue logic and burst counter live in the top module.

## Test plan
- Write A1, B2, C3 into the FIFO; `en`=1, `m_ready`=1 → `m_data` A1, B2, C3 on consecutive cycles. `m_last`=0 throughout; `busy` falls after C3.
- 8 words 00..07, `BURST_LEN`=4, `m_ready`=1 → `m_last`=1 exactly on 03 and 07. No gaps after the first word.
- 5 words, `m_ready`=0 for 10 cycles → exactly 3 `fifo_rd_n` pulses; `m_data`=first word held stable. After `m_ready`=1, all 5 words arrive in order.
- `en` dropped the cycle after a read strobe → that word still appears on `m_data`; state passes STOP→IDLE; no further strobes.
- Drive `fifo_underflow`=1 for one cycle → `err_underflow`=1 and it stays 1 until `rst_n`=0.
- Assert `rst_n`=0 with 2 words buffered → all outputs 0 immediately. After release, no stale words are presented.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: defaults, FSM states,
// output buffer geometry and the modulo-3 pointer step.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned BUF_DEPTH      = 3;
  localparam int unsigned CNT_W          = 2;
  localparam int unsigned PTR_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Advance a buffer pointer, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry circular output buffer; absorbs words already requested from the
// FIFO while the downstream consumer stalls.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues read strobes, hides the one-cycle read
// latency behind a 3-entry buffer, flags burst boundaries and sticky underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_underflow
);

  localparam int unsigned        BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic                  inflight_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  err_q;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] head;
  logic                  issue;
  logic                  hs;

  // Strobe only while buffer occupancy plus the outstanding read leaves room.
  assign issue = (state_q == ST_RUN) && !fifo_empty &&
                 (({1'b0, count} + {2'b00, inflight_q}) <= 3'd2);
  assign hs    = m_valid && m_ready;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (hs),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: begin
        if (en)               state_d = ST_RUN;
        else if (!inflight_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (hs) beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      beat_q     <= beat_d;
      err_q      <= err_q | fifo_underflow;
    end
  end

  assign fifo_rd_n     = issue;
  assign m_valid       = (count != '0);
  assign m_data        = head;
  assign m_last        = m_valid && (beat_q == BEAT_MAX);
  assign busy          = (state_q != ST_IDLE) || m_valid || inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a behavioural FIFO read port.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en = 1'b0;
  logic          fifo_rd_n;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err_underflow;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_rd_n      (fifo_rd_n),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: word appears on fifo_data the cycle after the strobe edge.
  logic [DW-1:0] fmem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_rd = 0;
  int n_bad_rd = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_n) begin
      n_rd <= n_rd + 1;
      if (fifo_empty) n_bad_rd <= n_bad_rd + 1;
      else begin
        fifo_data <= fmem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beat_exp = 0;
  int n_hs = 0;
  int n_last = 0;
  int first_hs = 0;
  int last_hs = 0;
  int cyc = 0;
  logic saw_rd = 1'b0;
  int base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge clk);
    saw_rd = fifo_rd_n;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_word", 32'(m_data), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(m_data), 32'(e));
        chk("sb_last", 32'(m_last), 32'(beat_exp == int'(BL) - 1));
        beat_exp = (beat_exp + 1) % int'(BL);
      end
      if (n_hs == 0) first_hs = cyc;
      last_hs = cyc;
      n_hs++;
      if (m_last) n_last++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    fmem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_rd_n", 32'(fifo_rd_n), 0);
    exp_q.delete();
    beat_exp = 0;
    n_hs = 0;
    n_last = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_until_rd(input int target, input int budget);
    for (int i = 0; i < budget && n_rd < target; i++) cycle();
    chk("rd_count_reached", 32'(n_rd >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) cycle();
    chk("busy_fall", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1;
    do_reset();

    // Three words streamed back to back
    wr(8'hA1); wr(8'hB2); wr(8'hC3);
    base = n_rd;
    m_ready = 1'b1;
    en = 1'b1;
    run_until_rd(base + 3, 20);
    en = 1'b0;
    wait_idle(20);
    chk("t1_n_hs", 32'(n_hs), 3);
    chk("t1_gapless", 32'(last_hs - first_hs), 2);
    chk("t1_n_last", 32'(n_last), 0);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);

    // Two full bursts of four
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'(i));
    base = n_rd;
    m_ready = 1'b1;
    en = 1'b1;
    run_until_rd(base + 8, 40);
    en = 1'b0;
    wait_idle(20);
    chk("t2_n_hs", 32'(n_hs), 8);
    chk("t2_gapless", 32'(last_hs - first_hs), 7);
    chk("t2_n_last", 32'(n_last), 2);

    // Downstream stall: at most three reads outstanding, head word held
    do_reset();
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    base = n_rd;
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (m_valid) chk("t3_hold", 32'(m_data), 32'h10);
    end
    chk("t3_three_reads", 32'(n_rd - base), 3);
    chk("t3_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    run_until_rd(base + 5, 30);
    en = 1'b0;
    wait_idle(20);
    chk("t3_n_hs", 32'(n_hs), 5);
    chk("t3_n_last", 32'(n_last), 1);
    chk("t3_sb_empty", 32'(exp_q.size()), 0);

    // en dropped right after a strobe: word still delivered, no further reads
    do_reset();
    wr(8'h55);
    m_ready = 1'b1;
    en = 1'b1;
    saw_rd = 1'b0;
    for (int i = 0; i < 10 && !saw_rd; i++) cycle();
    en = 1'b0;
    chk("t4_strobe_seen", 32'(saw_rd), 1);
    base = n_rd;
    wait_idle(20);
    chk("t4_word_out", 32'(n_hs), 1);
    wr(8'h66);
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_no_strobe_idle", 32'(n_rd - base), 0);
    chk("t4_no_word_idle", 32'(n_hs), 1);
    en = 1'b1;
    run_until_rd(base + 1, 10);
    en = 1'b0;
    wait_idle(20);
    chk("t4_restart_word", 32'(n_hs), 2);

    // Sticky underflow flag
    do_reset();
    chk("t5_err_clear", 32'(err_underflow), 0);
    fifo_underflow = 1'b1;
    cycle();
    fifo_underflow = 1'b0;
    cycle();
    chk("t5_err_set", 32'(err_underflow), 1);
    for (int i = 0; i < 5; i++) cycle();
    chk("t5_err_sticky", 32'(err_underflow), 1);

    // Reset with buffered words discards them
    do_reset();
    wr(8'hAA); wr(8'hBB);
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t6_buffered_valid", 32'(m_valid), 1);
    chk("t6_buffered_head", 32'(m_data), 32'hAA);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t6_no_stale_hs", 32'(n_hs), 0);
    chk("t6_no_stale_valid", 32'(m_valid), 0);

    chk("no_strobe_when_empty", 32'(n_bad_rd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
